spike_threshold_unit: RTL
=========================

Name: spike_threshold_unit

Overview:
- Downstream consumer of the accumulator stage in the ESTU datapath.
- Integrates successive accumulator results (SIZEIN+1 bit signed) into a saturating membrane register.
- Compares against a programmable threshold at each timestep boundary and emits a spike on a valid/ready handshake.
- Enforces a refractory window after each spike, in which incoming accumulator results are accepted and discarded.

Parameters:
- SIZEIN, 16, accumulator input width; acc_in is SIZEIN+1 bits.
- MEMW, 24, membrane register width (signed), MEMW > SIZEIN+1.
- REFR_W, 4, refractory counter width.
- CNT_W, 16, spike counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- acc_in  in  SIZEIN+1  signed accumulator result.
- acc_valid  in  1  acc_in valid.
- acc_last  in  1  qualifies acc_in as last sample of the timestep.
- acc_ready  out  1  block accepts acc_in.
- threshold  in  MEMW  signed firing threshold, sampled in S_CMP.
- refr_cycles  in  REFR_W  refractory length in cycles; 0 means none.
- spike_valid  out  1  spike pending.
- spike_ready  in  1  consumer takes spike.
- mem_out  out  MEMW  current membrane value (signed).
- spike_cnt  out  CNT_W  total spikes handed off, wraps.
- busy  out  1  high in any state other than S_INT.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous, active-high.
- Reset values: state=S_INT, mem_out=0, spike_valid=0, spike_cnt=0, refractory counter=0, acc_ready=1, busy=0.
- Handshake: a transfer occurs when acc_valid & acc_ready are high on a clock edge.
- acc_ready is 1 in S_INT and S_REF, 0 in S_CMP and S_FIRE.
- Arithmetic: sum = mem + sign-extended acc_in, saturated to [-2^(MEMW-1), 2^(MEMW-1)-1]. No wrap-around is permitted.
- State S_INT:
  - On a transfer, mem <= sat(sum).
  - If acc_last is also set, go to S_CMP.
- State S_CMP (1 cycle):
  - If mem >= threshold (signed compare), go to S_FIRE and set spike_valid=1 on entry.
  - Else apply leak (see Optional Feature) and return to S_INT.
- State S_FIRE:
  - spike_valid is held high and mem_out is held stable until spike_ready.
  - On spike_valid & spike_ready: spike_valid<=0, mem<=0, spike_cnt<=spike_cnt+1 (wraps at 2^CNT_W).
  - Next state is S_REF if refr_cycles!=0, else S_INT.
- State S_REF:
  - counter loads refr_cycles on entry, then decrements once per cycle.
  - Transfers are accepted (acc_ready=1) and discarded; mem stays 0.
  - When counter reaches 1 on a clock edge, go to S_INT, so S_REF lasts exactly refr_cycles cycles.
  - An acc_last received in S_REF does not trigger S_CMP.
- Latency: acc_last transfer to spike_valid high is 2 cycles (one edge into S_CMP, one into S_FIRE).
- Boundary conditions:
  - threshold equal to mem fires.
  - Negative threshold with mem=0 fires on the first timestep.
  - spike_ready held high while spike_valid is low has no effect.
  - acc_valid low in S_INT: mem unchanged.
  - threshold and refr_cycles changes outside S_CMP and S_FIRE entry are ignored until next use.
  - rst asserted mid-S_FIRE: spike dropped, spike_cnt cleared, state S_INT immediately (asynchronous).

Optional Feature:
- Macro: ESTU_SPIKE_LEAK_EN.
- When defined:
  - Adds input port leak_shift [3:0].
  - On a non-firing S_CMP exit: mem <= mem - (mem >>> leak_shift), arithmetic shift, i.e. decay toward 0.
  - leak_shift=0 clears mem.
  - Leak is never applied on a firing timestep.
- When undefined: no port, and mem is retained unchanged across timesteps.

Decomposition:
- Shared package estu_spike_pkg holds:
  - state encoding localparams S_INT=2'd0, S_CMP=2'd1, S_FIRE=2'd2, S_REF=2'd3;
  - a sat_add function parameterised by MEMW.
- One sub-module, spike_refr_counter: loadable down-counter with a done flag (REFR_W wide), instantiated once.
- FSM and membrane logic stay in the top.

Test Plan:
- Threshold crossing: threshold=100; inputs 40,40,30(last) -> mem 110, spike_valid high 2 cycles after the last transfer. With spike_ready=1: mem=0, spike_cnt=1.
- Sub-threshold: threshold=100; inputs 50, 49(last) -> no spike, mem=99 retained without leak. A following 1(last) -> spike.
- Backpressure: spike_ready=0 for 5 cycles after firing -> spike_valid and mem_out stable, acc_ready=0. Release -> exactly one spike_cnt increment.
- Refractory: refr_cycles=3; after handoff, 3 cycles of acc_ready=1 with input 1000(last) -> discarded, mem=0, no spike. Then back to S_INT.
- Saturation: MEMW=24; feed +65535 repeatedly (threshold max) -> mem clamps at 8388607 and never goes negative. Same check with negative inputs clamping at -8388608.
- Async reset during S_FIRE: pulse rst between edges -> spike_valid, mem_out, spike_cnt are 0 immediately and state is S_INT. With ESTU_SPIKE_LEAK_EN: leak_shift=1, mem=80 non-firing -> mem=40.

Source files
------------

// File: rtl/estu_spike_pkg.sv
// Shared definitions for the ESTU spike threshold stage: FSM state encoding
// and a width-parameterised saturating adder.
package estu_spike_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_INT  = 2'd0;
   localparam state_t S_CMP  = 2'd1;
   localparam state_t S_FIRE = 2'd2;
   localparam state_t S_REF  = 2'd3;

   localparam int SAT_W = 64;

   // Operands arrive sign-extended to SAT_W bits; the result is clamped to the
   // signed range of a w-bit register (w < SAT_W) and returned sign-extended.
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input int                      w
   );
      logic signed [SAT_W-1:0] sum;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      sum   = a + b;
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (w - 1));
      if (sum > max_v) begin
         sat_add = max_v;
      end else if (sum < min_v) begin
         sat_add = min_v;
      end else begin
         sat_add = sum;
      end
   endfunction

endpackage

// File: rtl/spike_refr_counter.sv
// Loadable refractory down-counter; done is high while the count equals 1,
// i.e. during the last cycle of the refractory window.
module spike_refr_counter #(
   parameter int REFR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [REFR_W-1:0] load_val,
   input  logic              en,
   output logic [REFR_W-1:0] count,
   output logic              done
);

   logic [REFR_W-1:0] count_r;
   logic [REFR_W-1:0] count_next_s;
   logic              done_r;

   // next count: load wins over decrement, and the counter parks at zero
   always_comb begin
      count_next_s = count_r;
      if (load) begin
         count_next_s = load_val;
      end else if (en && (count_r != {REFR_W{1'b0}})) begin
         count_next_s = count_r - REFR_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // count and done registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {REFR_W{1'b0}};
         done_r  <= 1'b0;
      end else begin
         count_r <= count_next_s;
         done_r  <= (count_next_s == REFR_W'(1));
      end
   end

   assign count = count_r;
   assign done  = done_r;

endmodule

// File: rtl/spike_threshold_unit.sv
// Integrate-and-fire stage: saturating membrane, threshold compare per timestep,
// spike handshake and refractory window. Optional leak via ESTU_SPIKE_LEAK_EN.
module spike_threshold_unit
   import estu_spike_pkg::*;
#(
   parameter int SIZEIN = 16,
   parameter int MEMW   = 24,
   parameter int REFR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIZEIN:0]   acc_in,
   input  logic                     acc_valid,
   input  logic                     acc_last,
   output logic                     acc_ready,
   input  logic signed [MEMW-1:0]   threshold,
   input  logic        [REFR_W-1:0] refr_cycles,
`ifdef ESTU_SPIKE_LEAK_EN
   input  logic        [3:0]        leak_shift,
`endif
   output logic                     spike_valid,
   input  logic                     spike_ready,
   output logic signed [MEMW-1:0]   mem_out,
   output logic        [CNT_W-1:0]  spike_cnt,
   output logic                     busy
);

   state_t                   state_r;
   logic signed [MEMW-1:0]   mem_r;
   logic signed [MEMW-1:0]   sum_s;
   logic                     spike_valid_r;
   logic        [CNT_W-1:0]  spike_cnt_r;
   logic                     acc_ready_r;
   logic                     busy_r;
   logic                     handoff_s;
   logic                     refr_load_s;
   logic                     refr_en_s;
   logic                     refr_done_s;
   logic        [REFR_W-1:0] refr_count_s;

   // saturating membrane update and refractory counter controls
   always_comb begin
      sum_s = MEMW'(sat_add({{(SAT_W-MEMW){mem_r[MEMW-1]}}, mem_r},
                            {{(SAT_W-SIZEIN-1){acc_in[SIZEIN]}}, acc_in},
                            MEMW));
      handoff_s   = (state_r == S_FIRE) && spike_valid_r && spike_ready;
      refr_load_s = handoff_s && (refr_cycles != {REFR_W{1'b0}});
      refr_en_s   = (state_r == S_REF);
   end

   spike_refr_counter #(
      .REFR_W(REFR_W)
   ) u_refr (
      .clk      (clk),
      .rst      (rst),
      .load     (refr_load_s),
      .load_val (refr_cycles),
      .en       (refr_en_s),
      .count    (refr_count_s),
      .done     (refr_done_s)
   );

   // main FSM; acc_ready and busy are registered alongside the state they mirror
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_INT;
         mem_r         <= {MEMW{1'b0}};
         spike_valid_r <= 1'b0;
         spike_cnt_r   <= {CNT_W{1'b0}};
         acc_ready_r   <= 1'b1;
         busy_r        <= 1'b0;
      end else begin
         case (state_r)
            S_INT: begin
               if (acc_valid && acc_ready_r) begin
                  mem_r <= sum_s;
                  if (acc_last) begin
                     state_r     <= S_CMP;
                     acc_ready_r <= 1'b0;
                     busy_r      <= 1'b1;
                  end
               end
            end
            S_CMP: begin
               if (mem_r >= threshold) begin
                  state_r       <= S_FIRE;
                  spike_valid_r <= 1'b1;
               end else begin
`ifdef ESTU_SPIKE_LEAK_EN
                  mem_r <= mem_r - (mem_r >>> leak_shift);
`endif
                  state_r     <= S_INT;
                  acc_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            S_FIRE: begin
               if (handoff_s) begin
                  spike_valid_r <= 1'b0;
                  mem_r         <= {MEMW{1'b0}};
                  spike_cnt_r   <= spike_cnt_r + CNT_W'(1);
                  acc_ready_r   <= 1'b1;
                  if (refr_load_s) begin
                     state_r <= S_REF;
                  end else begin
                     state_r <= S_INT;
                     busy_r  <= 1'b0;
                  end
               end
            end
            S_REF: begin
               // transfers here are acknowledged but never reach the membrane
               if (refr_done_s) begin
                  state_r <= S_INT;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r       <= S_INT;
               spike_valid_r <= 1'b0;
               acc_ready_r   <= 1'b1;
               busy_r        <= 1'b0;
            end
         endcase
      end
   end

   assign acc_ready   = acc_ready_r;
   assign spike_valid = spike_valid_r;
   assign mem_out     = mem_r;
   assign spike_cnt   = spike_cnt_r;
   assign busy        = busy_r;

endmodule
